// File: rtl/hesap_istemci_if.sv
// Ports of the calculator requester: command port, calculator operand/result port and result port.
// master = hesap_istemci; slave = its surroundings (command source, calculator, result consumer).
interface hesap_istemci_if #(
    parameter int VERI_GENISLIK   = 32,
    parameter int TUR_GENISLIK    = 3,
    parameter int ETIKET_GENISLIK = 4
);
    logic                         komut_gecerli;
    logic                         komut_hazir;
    logic [VERI_GENISLIK-1:0]     komut_sayi1;
    logic [VERI_GENISLIK-1:0]     komut_sayi2;
    logic [TUR_GENISLIK-1:0]      komut_tur;
    logic [ETIKET_GENISLIK-1:0]   komut_etiket;

    logic [VERI_GENISLIK-1:0]     hm_sayi1;
    logic [VERI_GENISLIK-1:0]     hm_sayi2;
    logic [TUR_GENISLIK-1:0]      hm_tur;
    logic                         hm_basla;
    logic [2*VERI_GENISLIK-1:0]   hm_sonuc;
    logic                         hm_hazir;
    logic                         hm_gecerli;
    logic                         hm_tasma;

    logic                         sonuc_gecerli;
    logic                         sonuc_hazir;
    logic [2*VERI_GENISLIK-1:0]   sonuc;
    logic [ETIKET_GENISLIK-1:0]   sonuc_etiket;
    logic                         sonuc_islem_gecerli;
    logic                         sonuc_tasma;
    logic                         sonuc_zaman_asimi;
    logic                         mesgul;

    modport master (
        input  komut_gecerli, komut_sayi1, komut_sayi2, komut_tur, komut_etiket,
        output komut_hazir,
        output hm_sayi1, hm_sayi2, hm_tur, hm_basla,
        input  hm_sonuc, hm_hazir, hm_gecerli, hm_tasma,
        output sonuc_gecerli, sonuc, sonuc_etiket, sonuc_islem_gecerli, sonuc_tasma,
        output sonuc_zaman_asimi, mesgul,
        input  sonuc_hazir
    );

    modport slave (
        output komut_gecerli, komut_sayi1, komut_sayi2, komut_tur, komut_etiket,
        input  komut_hazir,
        input  hm_sayi1, hm_sayi2, hm_tur, hm_basla,
        output hm_sonuc, hm_hazir, hm_gecerli, hm_tasma,
        input  sonuc_gecerli, sonuc, sonuc_etiket, sonuc_islem_gecerli, sonuc_tasma,
        input  sonuc_zaman_asimi, mesgul,
        output sonuc_hazir
    );
endinterface

// File: rtl/hesap_istemci.sv
// Calculator requester: takes one tagged command, runs it on the calculator, returns the tagged result.
// Optional handshake timeout (parameter ZAMAN_ASIMI) is built when HESAP_ISTEMCI_ZAMAN_ASIMI_EN is defined.
module hesap_istemci #(
    parameter int VERI_GENISLIK   = 32,
    parameter int TUR_GENISLIK    = 3,
    parameter int ETIKET_GENISLIK = 4
`ifdef HESAP_ISTEMCI_ZAMAN_ASIMI_EN
    , parameter int ZAMAN_ASIMI   = 1024
`endif
) (
    input  logic            clk,
    input  logic            rst,
    hesap_istemci_if.master bus
);
    localparam logic [TUR_GENISLIK-1:0] TUR_DESTEKSIZ = '1;

    typedef enum logic [2:0] {BOS, GONDER, BEKLE_DUSUK, BEKLE_YUKSEK, SONUC} durum_t;

    durum_t                       durum_q, durum_d;
    logic [VERI_GENISLIK-1:0]     sayi1_q, sayi1_d, sayi2_q, sayi2_d;
    logic [TUR_GENISLIK-1:0]      tur_q, tur_d;
    logic [ETIKET_GENISLIK-1:0]   etiket_q, etiket_d;
    logic [2*VERI_GENISLIK-1:0]   sonuc_q, sonuc_d;
    logic                         islem_gecerli_q, islem_gecerli_d;
    logic                         tasma_q, tasma_d;
    logic                         kabul;
    logic                         zaman_asimi_olay;

    assign kabul = bus.komut_gecerli && (durum_q == BOS);

    always_comb begin
        // NOTE: every _d starts from its _q, so no path through this block can infer a latch.
        durum_d         = durum_q;
        sayi1_d         = sayi1_q;
        sayi2_d         = sayi2_q;
        tur_d           = tur_q;
        etiket_d        = etiket_q;
        sonuc_d         = sonuc_q;
        islem_gecerli_d = islem_gecerli_q;
        tasma_d         = tasma_q;
        unique case (durum_q)
            BOS: if (kabul) begin
                sayi1_d         = bus.komut_sayi1;
                sayi2_d         = bus.komut_sayi2;
                tur_d           = bus.komut_tur;
                etiket_d        = bus.komut_etiket;
                // Cleared here so the unsupported-code and timeout paths report zeros without extra muxing.
                sonuc_d         = '0;
                islem_gecerli_d = 1'b0;
                tasma_d         = 1'b0;
                durum_d         = (bus.komut_tur == TUR_DESTEKSIZ) ? SONUC : GONDER;
            end
            GONDER: durum_d = BEKLE_DUSUK;
            BEKLE_DUSUK: begin
                if (!bus.hm_hazir)          durum_d = BEKLE_YUKSEK;
                else if (zaman_asimi_olay)  durum_d = SONUC;
            end
            BEKLE_YUKSEK: begin
                if (bus.hm_hazir) begin
                    sonuc_d         = bus.hm_sonuc;
                    islem_gecerli_d = bus.hm_gecerli;
                    tasma_d         = bus.hm_tasma;
                    durum_d         = SONUC;
                end else if (zaman_asimi_olay) begin
                    durum_d = SONUC;
                end
            end
            SONUC: if (bus.sonuc_hazir) durum_d = BOS;
            default: durum_d = BOS;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            durum_q         <= BOS;
            sayi1_q         <= '0;
            sayi2_q         <= '0;
            tur_q           <= '0;
            etiket_q        <= '0;
            sonuc_q         <= '0;
            islem_gecerli_q <= 1'b0;
            tasma_q         <= 1'b0;
        end else begin
            durum_q         <= durum_d;
            sayi1_q         <= sayi1_d;
            sayi2_q         <= sayi2_d;
            tur_q           <= tur_d;
            etiket_q        <= etiket_d;
            sonuc_q         <= sonuc_d;
            islem_gecerli_q <= islem_gecerli_d;
            tasma_q         <= tasma_d;
        end
    end

    always_comb begin
        bus.komut_hazir   = (durum_q == BOS);
        bus.hm_basla      = (durum_q == GONDER);
        bus.sonuc_gecerli = (durum_q == SONUC);
        bus.mesgul        = (durum_q != BOS);
    end

    assign bus.hm_sayi1            = sayi1_q;
    assign bus.hm_sayi2            = sayi2_q;
    assign bus.hm_tur              = tur_q;
    assign bus.sonuc               = sonuc_q;
    assign bus.sonuc_etiket        = etiket_q;
    assign bus.sonuc_islem_gecerli = islem_gecerli_q;
    assign bus.sonuc_tasma         = tasma_q;

`ifdef HESAP_ISTEMCI_ZAMAN_ASIMI_EN
    localparam int SAYAC_W = $clog2(ZAMAN_ASIMI);

    logic [SAYAC_W-1:0] sayac_q, sayac_d;
    logic               zaman_asimi_q, zaman_asimi_d;
    logic               bekleme;

    assign bekleme = (durum_q == BEKLE_DUSUK) || (durum_q == BEKLE_YUKSEK);
    // Expires only while the awaited hm_hazir level has not arrived this cycle.
    assign zaman_asimi_olay = bekleme && (sayac_q == SAYAC_W'(ZAMAN_ASIMI - 1))
                              && (bus.hm_hazir == (durum_q == BEKLE_DUSUK));

    always_comb begin
        sayac_d       = '0;
        zaman_asimi_d = zaman_asimi_q;
        if (bekleme && (durum_d == durum_q)) sayac_d = sayac_q + SAYAC_W'(1);
        if (kabul)                 zaman_asimi_d = 1'b0;
        else if (zaman_asimi_olay) zaman_asimi_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sayac_q       <= '0;
            zaman_asimi_q <= 1'b0;
        end else begin
            sayac_q       <= sayac_d;
            zaman_asimi_q <= zaman_asimi_d;
        end
    end

    assign bus.sonuc_zaman_asimi = zaman_asimi_q;
`else
    assign zaman_asimi_olay      = 1'b0;
    assign bus.sonuc_zaman_asimi = 1'b0;
`endif
endmodule

// File: tb/tb_hesap_istemci.sv
// Bench for hesap_istemci: directed vector table, randomized commands against a behavioural calculator
// model, mid-transaction reset and (with HESAP_ISTEMCI_ZAMAN_ASIMI_EN) the handshake timeout.
module tb_hesap_istemci;
    localparam int VG    = 32;
    localparam int TG    = 3;
    localparam int EG    = 4;
    localparam int SINIR = 200;

    typedef struct {
        logic [VG-1:0]   sayi1;
        logic [VG-1:0]   sayi2;
        logic [TG-1:0]   tur;
        logic [EG-1:0]   etiket;
        int              gec;      // cycles after hm_basla before the calculator drops hm_hazir
        int              dusuk;    // cycles hm_hazir stays low (>= 2)
        int              bekle;    // cycles the consumer withholds sonuc_hazir
        logic [2*VG-1:0] sonuc;
        logic            gecerli;
        logic            tasma;
        int              gecikme;  // accept edge to first cycle with sonuc_gecerli
    } vektor_t;

    logic clk;
    logic rst;
    int   toplam;
    int   gecen;

    hesap_istemci_if #(.VERI_GENISLIK(VG), .TUR_GENISLIK(TG), .ETIKET_GENISLIK(EG)) bus ();

    hesap_istemci #(
        .VERI_GENISLIK(VG), .TUR_GENISLIK(TG), .ETIKET_GENISLIK(EG)
`ifdef HESAP_ISTEMCI_ZAMAN_ASIMI_EN
        , .ZAMAN_ASIMI(16)
`endif
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        toplam++;
        if (gercek === beklenen) gecen++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", ad, gercek, beklenen);
    endtask

    // The calculator this requester talks to: what it returns for each operation code.
    function automatic void hesap_modeli(input logic [VG-1:0] a, input logic [VG-1:0] b,
                                         input logic [TG-1:0] t, output logic [2*VG-1:0] s,
                                         output logic g, output logic ta);
        s = '0; g = 1'b1; ta = 1'b0;
        case (t)
            3'd0: begin s = {{VG{1'b0}}, a} + {{VG{1'b0}}, b}; ta = s[VG]; end
            3'd1: begin s = {{VG{1'b0}}, a - b}; ta = (a < b); end
            3'd2: s = {{VG{1'b0}}, a} * {{VG{1'b0}}, b};
            3'd3: if (b == '0) begin g = 1'b0; ta = 1'b1; end
                  else s = {{VG{1'b0}}, a / b};
            3'd4: s = {{VG{1'b0}}, a & b};
            3'd5: s = {{VG{1'b0}}, a | b};
            3'd6: s = {{VG{1'b0}}, a ^ b};
            default: g = 1'b0;
        endcase
    endfunction

    task automatic reset_degerleri(input string on);
        check({on, "_komut_hazir"}, 64'(bus.komut_hazir), 64'd1);
        check({on, "_kontrol"}, {60'd0, bus.mesgul, bus.hm_basla, bus.sonuc_gecerli, bus.sonuc_zaman_asimi}, 64'd0);
        check({on, "_hm_sayi"}, {bus.hm_sayi1, bus.hm_sayi2}, 64'd0);
        check({on, "_sonuc"}, bus.sonuc, 64'd0);
        check({on, "_alanlar"}, {57'd0, bus.hm_tur, bus.sonuc_etiket}, 64'd0);
        check({on, "_bayraklar"}, {62'd0, bus.sonuc_islem_gecerli, bus.sonuc_tasma}, 64'd0);
    endtask

    // One full command: accept, play the calculator, collect and acknowledge the result.
    task automatic islem(input vektor_t v);
        int              n, basla_say, basla_n;
        bit              kararli, tutma;
        logic [2*VG-1:0] cs;
        logic            cg, ct;
        hesap_modeli(v.sayi1, v.sayi2, v.tur, cs, cg, ct);
        check("komut_hazir_bos", 64'(bus.komut_hazir), 64'd1);
        bus.komut_gecerli = 1'b1;
        bus.komut_sayi1   = v.sayi1;
        bus.komut_sayi2   = v.sayi2;
        bus.komut_tur     = v.tur;
        bus.komut_etiket  = v.etiket;
        @(negedge clk);
        bus.komut_gecerli = 1'b0;
        bus.komut_sayi1   = $urandom;
        bus.komut_sayi2   = $urandom;
        bus.komut_etiket  = 4'($urandom);
        n = 1; basla_say = 0; basla_n = -1; kararli = 1'b1;
        while (!bus.sonuc_gecerli && n < SINIR) begin
            if (bus.hm_sayi1 !== v.sayi1 || bus.hm_sayi2 !== v.sayi2 || bus.hm_tur !== v.tur) kararli = 1'b0;
            if (bus.hm_basla) begin
                basla_say++;
                if (basla_n < 0) basla_n = n;
            end
            if (basla_n >= 0 && n == basla_n + v.gec) begin
                bus.hm_hazir   = 1'b0;
                bus.hm_sonuc   = {$urandom, $urandom};
                bus.hm_gecerli = ~cg;
                bus.hm_tasma   = ~ct;
            end
            if (basla_n >= 0 && n == basla_n + v.gec + v.dusuk) begin
                bus.hm_hazir   = 1'b1;
                bus.hm_sonuc   = cs;
                bus.hm_gecerli = cg;
                bus.hm_tasma   = ct;
            end
            @(negedge clk);
            n++;
        end
        check("gecikme", 64'(n), 64'(v.gecikme));
        check("sonuc", bus.sonuc, v.sonuc);
        check("sonuc_etiket", 64'(bus.sonuc_etiket), 64'(v.etiket));
        check("islem_gecerli", 64'(bus.sonuc_islem_gecerli), 64'(v.gecerli));
        check("sonuc_tasma", 64'(bus.sonuc_tasma), 64'(v.tasma));
        check("zaman_asimi_yok", 64'(bus.sonuc_zaman_asimi), 64'd0);
        check("hm_kararli", 64'(kararli), 64'd1);
        bus.hm_sonuc   = {$urandom, $urandom};
        bus.hm_gecerli = ~cg;
        bus.hm_tasma   = ~ct;
        tutma = 1'b1;
        for (int i = 0; i < v.bekle; i++) begin
            bus.komut_gecerli = 1'b1;
            bus.komut_sayi1   = $urandom;
            bus.komut_tur     = 3'($urandom_range(0, 6));
            @(negedge clk);
            if (bus.hm_basla) basla_say++;
            if (!bus.sonuc_gecerli || bus.komut_hazir || bus.sonuc !== v.sonuc ||
                bus.sonuc_etiket !== v.etiket || bus.sonuc_islem_gecerli !== v.gecerli ||
                bus.sonuc_tasma !== v.tasma || bus.hm_sayi1 !== v.sayi1) tutma = 1'b0;
        end
        if (v.bekle > 0) check("sonuc_tutma", 64'(tutma), 64'd1);
        bus.komut_gecerli = 1'b0;
        bus.sonuc_hazir   = 1'b1;
        @(negedge clk);
        bus.sonuc_hazir   = 1'b0;
        if (bus.hm_basla) basla_say++;
        check("el_sikisma_sonrasi", {61'd0, bus.sonuc_gecerli, bus.komut_hazir, bus.mesgul}, 64'b010);
        check("hm_basla_sayisi", 64'(basla_say), (v.tur == 3'b111) ? 64'd0 : 64'd1);
        check("hm_son_komut", {bus.hm_sayi1, bus.hm_sayi2}, {v.sayi1, v.sayi2});
    endtask

    initial begin
        vektor_t tablo[8];
        vektor_t v;
        int      n;
        bit      bayat;
        toplam = 0; gecen = 0;
        clk = 1'b0; rst = 1'b0;
        bus.komut_gecerli = 1'b0; bus.komut_sayi1 = '0; bus.komut_sayi2 = '0;
        bus.komut_tur = '0; bus.komut_etiket = '0; bus.sonuc_hazir = 1'b0;
        bus.hm_hazir = 1'b1; bus.hm_sonuc = '0; bus.hm_gecerli = 1'b0; bus.hm_tasma = 1'b0;
        #1;
        reset_degerleri("reset");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        //          sayi1          sayi2          tur   etiket gec dusuk bekle sonuc                 gec  tasma lat
        tablo[0] = '{32'd5,         32'd7,         3'd0, 4'hA,  0,  2,    0,    64'd12,               1'b1, 1'b0, 4};
        tablo[1] = '{32'd3,         32'd9,         3'd7, 4'h5,  0,  2,    0,    64'd0,                1'b0, 1'b0, 1};
        tablo[2] = '{32'd7,         32'd0,         3'd3, 4'hC,  1,  3,    0,    64'd0,                1'b0, 1'b1, 6};
        tablo[3] = '{32'hFFFF_FFFF, 32'd1,         3'd0, 4'h3,  0,  2,    0,    64'h1_0000_0000,      1'b1, 1'b1, 4};
        tablo[4] = '{32'd1,         32'd2,         3'd1, 4'h7,  2,  2,    0,    64'h0000_0000_FFFF_FFFF, 1'b1, 1'b1, 6};
        tablo[5] = '{32'h0001_0000, 32'h0001_0000, 3'd2, 4'hF,  0,  3,    1,    64'h1_0000_0000,      1'b1, 1'b0, 5};
        tablo[6] = '{32'd11,        32'd22,        3'd4, 4'h2,  0,  2,    10,   64'd2,                1'b1, 1'b0, 4};
        tablo[7] = '{32'd100,       32'd7,         3'd3, 4'h9,  3,  2,    2,    64'd14,               1'b1, 1'b0, 7};
        for (int i = 0; i < 8; i++) islem(tablo[i]);

        for (int i = 0; i < 40; i++) begin
            v.sayi1  = $urandom;
            v.sayi2  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            v.tur    = 3'($urandom_range(0, 7));
            v.etiket = 4'($urandom);
            v.gec    = $urandom_range(0, 3);
            v.dusuk  = $urandom_range(2, 5);
            v.bekle  = $urandom_range(0, 3);
            hesap_modeli(v.sayi1, v.sayi2, v.tur, v.sonuc, v.gecerli, v.tasma);
            // Unsupported code goes straight to the result; otherwise valid follows the hm_hazir rise by one cycle.
            v.gecikme = (v.tur == 3'b111) ? 1 : 2 + v.gec + v.dusuk;
            islem(v);
        end

        bus.komut_gecerli = 1'b1; bus.komut_sayi1 = 32'd9; bus.komut_sayi2 = 32'd4;
        bus.komut_tur = 3'd0; bus.komut_etiket = 4'h6;
        @(negedge clk);
        bus.komut_gecerli = 1'b0; bus.hm_hazir = 1'b0;
        repeat (2) @(negedge clk);
        check("bekle_yuksek_mesgul", 64'(bus.mesgul), 64'd1);
        rst = 1'b0;
        #1;
        reset_degerleri("orta_reset");
        @(negedge clk);
        rst = 1'b1; bus.hm_hazir = 1'b1; bus.hm_sonuc = 64'd13; bus.hm_gecerli = 1'b1;
        bayat = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.sonuc_gecerli || bus.hm_basla || bus.mesgul || !bus.komut_hazir) bayat = 1'b1;
        end
        check("reset_sonrasi_bayat_sonuc", 64'(bayat), 64'd0);

`ifdef HESAP_ISTEMCI_ZAMAN_ASIMI_EN
        bus.komut_gecerli = 1'b1; bus.komut_sayi1 = 32'd5; bus.komut_sayi2 = 32'd7;
        bus.komut_tur = 3'd0; bus.komut_etiket = 4'hB;
        bus.hm_sonuc = 64'hDEAD; bus.hm_gecerli = 1'b1; bus.hm_tasma = 1'b1;
        @(negedge clk);
        bus.komut_gecerli = 1'b0;
        n = 1;
        while (!bus.sonuc_gecerli && n < SINIR) begin
            @(negedge clk);
            n++;
        end
        check("zaman_asimi_gecikme", 64'(n), 64'd18);
        check("zaman_asimi_bayrak", 64'(bus.sonuc_zaman_asimi), 64'd1);
        check("zaman_asimi_sonuc", bus.sonuc, 64'd0);
        check("zaman_asimi_bayraklar", {62'd0, bus.sonuc_islem_gecerli, bus.sonuc_tasma}, 64'd0);
        check("zaman_asimi_etiket", 64'(bus.sonuc_etiket), 64'hB);
        bus.sonuc_hazir = 1'b1;
        @(negedge clk);
        bus.sonuc_hazir = 1'b0;
        check("zaman_asimi_bos", 64'(bus.komut_hazir), 64'd1);
`else
        n = 0;
`endif

        $display("%0d/%0d checks passed", gecen, toplam);
        $finish;
    end
endmodule
